aes_enc_iter: RTL and testbench
===============================

AES_ENC_ITER -- requirements
Module: aes_enc_iter

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; only 10 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port keys_ready  input  1  high while the key scheduler holds a valid round-key set.
REQ-005 SHALL have port rk_idx  output  4  index (0..10) of the round key requested this cycle.
REQ-006 SHALL have port rk_data  input  128  round key rk_idx, combinational from the scheduler key store, same cycle.
REQ-007 SHALL have port in_valid  input  1  plaintext offered.
REQ-008 SHALL have port in_ready  output  1  block can accept plaintext.
REQ-009 SHALL have port pt_in  input  128  plaintext; bits [127:120] = byte 0.
REQ-010 SHALL have port out_valid  output  1  ciphertext available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts ciphertext.
REQ-012 SHALL have port ct_out  output  128  ciphertext, same byte order as pt_in.
REQ-013 SHALL have port busy  output  1  high in ROUND or DONE.
REQ-014 SHALL have port aborted  output  1  one-cycle pulse when an operation is cancelled.

Function
REQ-015 SHALL use FIPS-197 state mapping: byte k = row k%4, column k/4.
REQ-016 SHALL implement FSM states IDLE, ROUND, DONE; reset state IDLE.
REQ-017 SHALL drive in_ready = (state==IDLE) && keys_ready, combinationally.
REQ-018 SHALL drive rk_idx = 0 in IDLE, the round counter (1..10) in ROUND, and 0 in DONE.
REQ-019 On edge with in_valid && in_ready: state register <= pt_in ^ rk_data, round counter <= 1, go to ROUND.
REQ-020 In ROUND, rounds 1..9: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk_data; counter +1.
REQ-021 In ROUND, round 10: state <= ShiftRows(SubBytes(state)) ^ rk_data; go to DONE.
REQ-022 MixColumns SHALL use GF(2^8) xtime with reduction polynomial 0x11B.
REQ-023 Latency: acceptance at edge E0; out_valid high from edge E10, i.e. the 10th edge after acceptance.
REQ-024 In DONE: out_valid=1, ct_out = state register, held stable until out_valid && out_ready.
REQ-025 On out_valid && out_ready: go to IDLE; in_ready may rise the following cycle. No same-cycle accept and deliver.
REQ-026 ct_out SHALL be the state register in all states; it is qualified only by out_valid.
REQ-027 keys_ready low during ROUND: abort to IDLE next edge, aborted=1 for that one cycle, no out_valid.
REQ-028 keys_ready low in DONE: no effect; the result is already final.
REQ-029 in_valid while not in_ready: ignored; pt_in is not sampled.

Reset
REQ-030 On rst: state IDLE, counter 0, state register 0, out_valid 0, busy 0, aborted 0; in_ready follows REQ-017.
REQ-031 rst asserted mid-operation discards the operation with no aborted pulse.

Structure
REQ-032 Shared package aes_pkg SHALL hold NR, the 128-bit block type, the FSM state enum, and xtime/MixColumns functions.
REQ-033 Combinational sub-module aes_round SHALL take state, round key and a last-round flag, and instantiate 16 existing sbox cells.
REQ-034 The block SHALL keep a single aes_round instance, reused every round; no pipeline unrolling.

Verification
REQ-035 Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after accept.
REQ-036 Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-037 out_ready low for 5 cycles after out_valid -> ct_out and out_valid stable; in_ready low throughout.
REQ-038 keys_ready dropped at round 4 -> aborted pulse 1 cycle, IDLE, no out_valid; next block with keys restored gives correct ct.
REQ-039 rst pulsed at round 6 -> all outputs at reset values immediately; in_valid held during rst is not accepted.
REQ-040 in_valid held high across 3 blocks, out_ready=1 -> 3 correct results, one accept per 12 cycles, none while busy.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types and GF(2^8) helpers for the iterative encryptor.
// Byte k of a block sits at bits [127-8k -: 8] (row k%4, column k/4).
package aes_pkg;
  localparam int NR = 10;

  typedef logic [127:0] block_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r rotates left by r columns.
  function automatic block_t shift_rows(input block_t s);
    block_t r;
    r = '0;
    for (int k = 0; k < 16; k++)
      r[127-8*k -: 8] = s[127-8*((k % 4) + 4*(((k / 4) + (k % 4)) % 4)) -: 8];
    return r;
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction
endpackage

// File: rtl/aes_enc_iter_if.sv
// Plaintext-in / ciphertext-out valid-ready bundle for aes_enc_iter.
interface aes_enc_iter_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t pt_in;
  logic   out_valid;
  logic   out_ready;
  block_t ct_out;

  modport master (output in_valid, pt_in, out_ready, input in_ready, out_valid, ct_out);
  modport slave  (input in_valid, pt_in, out_ready, output in_ready, out_valid, ct_out);
endinterface

// File: rtl/aes_round.sv
// One combinational AES encryption round; MixColumns is skipped when last is set.
module aes_round
  import aes_pkg::*;
(
  input  block_t st,
  input  block_t rk,
  input  logic   last,
  output block_t nxt
);
  block_t sb;
  block_t sr;

  for (genvar k = 0; k < 16; k++) begin : g_sbox
    aes_sbox u_sbox (.x(st[127-8*k -: 8]), .y(sb[127-8*k -: 8]));
  end

  assign sr  = shift_rows(sb);
  assign nxt = (last ? sr : mix_columns(sr)) ^ rk;
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box cell: one byte through a 16x16 constant table, purely combinational.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  localparam logic [127:0] ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [127:0] row;
  logic [6:0]   sh;

  // Column 0 of a row lives in the top byte, so the shift is 8*(15-col).
  assign row = ROWS[x[7:4]];
  assign sh  = {~x[3:0], 3'b000};
  assign y   = row[sh +: 8];
endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one shared round datapath, result 10 edges after accept.
// Round keys are fetched by index from an external key store in the same cycle.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          keys_ready,
  output logic [3:0]    rk_idx,
  input  block_t        rk_data,
  aes_enc_iter_if.slave io,
  output logic          busy,
  output logic          aborted
);
  state_t     state;
  state_t     state_nxt;
  block_t     st_q;
  block_t     round_out;
  logic [3:0] cnt;
  logic       accept;
  logic       last;

  assign accept    = io.in_valid && io.in_ready;
  assign last      = (cnt == 4'(NR));
  assign io.ct_out = st_q;

  aes_round u_round (.st(st_q), .rk(rk_data), .last(last), .nxt(round_out));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Losing the key set mid-operation wins over finishing the round.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (!keys_ready) state_nxt = IDLE;
               else if (last)   state_nxt = DONE;
      DONE:    if (io.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    io.in_ready  = (state == IDLE) && keys_ready;
    io.out_valid = (state == DONE);
    busy         = (state == ROUND) || (state == DONE);
    rk_idx       = (state == ROUND) ? cnt : 4'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= '0;
      cnt     <= 4'd0;
      aborted <= 1'b0;
    end else begin
      aborted <= (state == ROUND) && !keys_ready;
      if (accept) begin
        st_q <= io.pt_in ^ rk_data;
        cnt  <= 4'd1;
      end else if ((state == ROUND) && keys_ready) begin
        st_q <= round_out;
        if (!last) cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_aes_enc_iter.sv
// Randomized bench for aes_enc_iter against a byte-level AES-128 model built from GF(2^8) math.
module tb_aes_enc_iter;
  logic         clk = 1'b0;
  logic         rst;
  logic         keys_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         busy;
  logic         aborted;
  logic [127:0] rk_tbl [16];
  logic [7:0]   sbox_m [256];
  int           total = 0;
  int           bad = 0;

  aes_enc_iter_if io ();

  aes_enc_iter #(.NR(10)) dut (
    .clk(clk), .rst(rst), .keys_ready(keys_ready), .rk_idx(rk_idx),
    .rk_data(rk_data), .io(io), .busy(busy), .aborted(aborted)
  );

  always #5 clk = ~clk;
  assign rk_data = rk_tbl[rk_idx];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
        for (int i = 0; i < 16; i++) t[i] = s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
        if (r < 10) begin
          for (int c = 0; c < 4; c++) begin
            s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
            s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
            s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
            s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
          end
        end else begin
          s = t;
        end
      end
      k = round_key(key, r);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic load_key(input logic [127:0] key);
    for (int r = 0; r <= 10; r++) rk_tbl[r] = round_key(key, r);
    for (int r = 11; r < 16; r++) rk_tbl[r] = '0;
  endtask

  task automatic test_reset();
    load_key('0);
    rst = 1'b1; keys_ready = 1'b1;
    io.in_valid = 1'b0; io.pt_in = '0; io.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", io.in_ready); end
    total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", io.out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (aborted !== 1'b0) begin bad++; $display("FAIL reset_aborted: got %b want 0", aborted); end
    total++; if (io.ct_out !== 128'h0) begin bad++; $display("FAIL reset_ct_out: got %h want 0", io.ct_out); end
    total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL reset_rk_idx: got %0d want 0", rk_idx); end
    keys_ready = 1'b0;
    #1;
    total++; if (io.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_nokeys: got %b want 0", io.in_ready); end
    keys_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  // Single block, out_ready raised as soon as the result appears.
  task automatic test_kat(input string nm, input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] ct_exp);
    int n;
    bit rk_ok;
    load_key(key);
    @(negedge clk);
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got %b want 1", nm, io.in_ready); end
    io.in_valid = 1'b1; io.pt_in = pt;
    @(negedge clk);
    io.in_valid = 1'b0; io.pt_in = ~pt;
    n = 0; rk_ok = 1'b1;
    while (io.out_valid !== 1'b1 && n < 40) begin
      if (rk_idx !== 4'(n + 1) || busy !== 1'b1 || io.in_ready !== 1'b0) rk_ok = 1'b0;
      @(negedge clk); n++;
    end
    total++; if (n != 10) begin bad++; $display("FAIL %s_latency: got %0d edges want 10", nm, n); end
    total++; if (!rk_ok) begin bad++; $display("FAIL %s_rk_idx_seq: got out-of-order index/busy want 1..10 busy", nm); end
    total++; if (io.ct_out !== ct_exp) begin bad++; $display("FAIL %s_ct: got %h want %h", nm, io.ct_out, ct_exp); end
    total++; if (rk_idx !== 4'd0) begin bad++; $display("FAIL %s_rk_idx_done: got %0d want 0", nm, rk_idx); end
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    total++; if (io.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_release: got valid=%b busy=%b want 0 0", nm, io.out_valid, busy); end
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_after: got %b want 1", nm, io.in_ready); end
  endtask

  task automatic test_random();
    logic [127:0] k, p;
    for (int i = 0; i < 4; i++) begin
      k = rand128(); p = rand128();
      test_kat("rand", k, p, ref_enc(k, p));
    end
  endtask

  // Result held under backpressure; keys_ready dropped while DONE has no effect.
  task automatic test_backpressure();
    logic [127:0] k, p, exp;
    int n;
    bit stable_ok;
    k = rand128(); p = rand128(); exp = ref_enc(k, p);
    load_key(k);
    @(negedge clk);
    io.in_valid = 1'b1; io.pt_in = p;
    @(negedge clk);
    io.pt_in = rand128();
    n = 0;
    while (io.out_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    total++; if (io.ct_out !== exp) begin bad++; $display("FAIL bp_ct: got %h want %h", io.ct_out, exp); end
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) keys_ready = 1'b0;
      @(negedge clk);
      if (io.out_valid !== 1'b1 || io.ct_out !== exp || io.in_ready !== 1'b0 || busy !== 1'b1) stable_ok = 1'b0;
    end
    total++; if (!stable_ok) begin bad++; $display("FAIL bp_hold: got ct=%h valid=%b want %h 1", io.ct_out, io.out_valid, exp); end
    io.in_valid = 1'b0; keys_ready = 1'b1; io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    total++; if (io.out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL bp_release: got valid=%b busy=%b want 0 0", io.out_valid, busy); end
  endtask

  task automatic test_abort();
    logic [127:0] k, p;
    int n, pulses;
    bit no_out;
    k = rand128(); p = rand128();
    load_key(k);
    @(negedge clk);
    io.in_valid = 1'b1; io.pt_in = p;
    @(negedge clk);
    io.in_valid = 1'b0;
    n = 0;
    while (rk_idx !== 4'd4 && n < 20) begin @(negedge clk); n++; end
    total++; if (rk_idx !== 4'd4) begin bad++; $display("FAIL abort_reach_round4: got %0d want 4", rk_idx); end
    keys_ready = 1'b0;
    @(negedge clk);
    total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_pulse: got %b want 1", aborted); end
    total++; if (busy !== 1'b0 || io.out_valid !== 1'b0 || io.in_ready !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%b valid=%b ready=%b want 0 0 0", busy, io.out_valid, io.in_ready);
    end
    keys_ready = 1'b1;
    no_out = 1'b1; pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (io.out_valid !== 1'b0) no_out = 1'b0;
      if (aborted !== 1'b0) pulses++;
    end
    total++; if (!no_out) begin bad++; $display("FAIL abort_no_out_valid: got out_valid=1 want 0"); end
    total++; if (pulses != 0) begin bad++; $display("FAIL abort_pulse_width: got %0d extra cycles want 0", pulses); end
    k = rand128(); p = rand128();
    test_kat("post_abort", k, p, ref_enc(k, p));
  endtask

  task automatic test_reset_mid();
    logic [127:0] k, p;
    int n;
    bit ok;
    k = rand128(); p = rand128();
    load_key(k);
    @(negedge clk);
    io.in_valid = 1'b1; io.pt_in = p;
    @(negedge clk);
    io.in_valid = 1'b0;
    n = 0;
    while (rk_idx !== 4'd6 && n < 20) begin @(negedge clk); n++; end
    total++; if (rk_idx !== 4'd6) begin bad++; $display("FAIL rstmid_reach_round6: got %0d want 6", rk_idx); end
    rst = 1'b1; io.in_valid = 1'b1; io.pt_in = rand128();
    #1;
    total++; if (busy !== 1'b0 || io.out_valid !== 1'b0 || aborted !== 1'b0) begin
      bad++; $display("FAIL rstmid_flags: got busy=%b valid=%b aborted=%b want 0 0 0", busy, io.out_valid, aborted);
    end
    total++; if (io.ct_out !== 128'h0 || rk_idx !== 4'd0) begin bad++; $display("FAIL rstmid_regs: got ct=%h idx=%0d want 0 0", io.ct_out, rk_idx); end
    total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", io.in_ready); end
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin rst = 1'b0; io.in_valid = 1'b0; end
      @(negedge clk);
      if (busy !== 1'b0 || aborted !== 1'b0 || io.out_valid !== 1'b0) ok = 1'b0;
    end
    total++; if (!ok) begin bad++; $display("FAIL rstmid_no_accept: got busy/aborted/valid set want all 0"); end
  endtask

  // in_valid held across three blocks with out_ready high.
  task automatic test_back_to_back();
    logic [127:0] k;
    logic [127:0] expq [$];
    logic [127:0] e;
    int gaps [$];
    int accepts, results, cyc, last_acc;
    bit acc_prev, overlap_ok;
    k = rand128();
    load_key(k);
    accepts = 0; results = 0; cyc = 0; last_acc = 0; acc_prev = 1'b0; overlap_ok = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b1; io.in_valid = 1'b1; io.pt_in = rand128();
    while (results < 3 && cyc < 200) begin
      if (acc_prev) begin
        io.pt_in = rand128();
        if (accepts == 3) io.in_valid = 1'b0;
        acc_prev = 1'b0;
      end
      if (busy === 1'b1 && io.in_ready === 1'b1) overlap_ok = 1'b0;
      if (io.out_valid === 1'b1) begin
        e = (expq.size() > 0) ? expq.pop_front() : ~io.ct_out;
        total++; if (io.ct_out !== e) begin bad++; $display("FAIL b2b_ct%0d: got %h want %h", results, io.ct_out, e); end
        results++;
      end
      if (io.in_valid === 1'b1 && io.in_ready === 1'b1) begin
        expq.push_back(ref_enc(k, io.pt_in));
        if (accepts > 0) gaps.push_back(cyc - last_acc);
        last_acc = cyc; accepts++; acc_prev = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    io.in_valid = 1'b0; io.out_ready = 1'b0;
    total++; if (results != 3 || accepts != 3) begin bad++; $display("FAIL b2b_count: got results=%0d accepts=%0d want 3 3", results, accepts); end
    total++; if (!overlap_ok) begin bad++; $display("FAIL b2b_ready_while_busy: got in_ready during busy want none"); end
    foreach (gaps[i]) begin
      total++; if (gaps[i] != 12) begin bad++; $display("FAIL b2b_gap%0d: got %0d cycles want 12", i, gaps[i]); end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_kat("fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
    test_kat("fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
             128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    test_random();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
